rf_wb_sched: RTL and testbench

- Write-port scheduler and scoreboard for the 32x32 integer register file (two async read ports, one sync write port, x0 hardwired zero).
- Shares the single RF write port between the in-order pipeline writeback (P) and a long-latency unit (L, e.g. divider or load-miss return).
- Tracks destination registers with an L result outstanding and flags RAW/WAW hazards to the issue stage.
- Sits between writeback/LLU and the RF write port; the registered outputs drive the RF write enable, address and data directly.

---
 rtl/rf_wb_sched.sv | 147 ++++++++++++++
 tb/tb_rf_wb_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: arbitrates pipeline (P) and long-latency (L) writebacks and keeps the L scoreboard.
// Optional trace output is enabled by defining RF_WB_TRACE_EN.
module rf_wb_sched #(
    parameter int STARVE_LIMIT = 4,
    parameter int OUTST_MAX    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_valid,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    output logic        p_ready,
    input  logic        l_valid,
    input  logic [4:0]  l_addr,
    input  logic [31:0] l_data,
    output logic        l_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_ready,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    output logic        hazard,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          src_l_q, src_l_d;
    logic [31:0]   busy_q, busy_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starve_q, starve_d;
    logic [3:0]    outst_q, outst_d;

    logic p_nonnull, p_acc, l_acc, iss_acc;

    always_comb begin
        p_nonnull = p_valid && (p_addr != '0);
        if (starve_q && l_valid) begin
            p_ready = 1'b0;
            l_ready = 1'b1;
        end else begin
            p_ready = 1'b1;
            l_ready = l_valid && !p_nonnull;
        end
        p_acc     = p_valid && p_ready;
        l_acc     = l_valid && l_ready;
        iss_ready = (outst_q < 4'(OUTST_MAX));
        iss_acc   = iss_valid && iss_ready;
        hazard    = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
    end

    // P and L accepts never carry non-null writes in the same cycle, so one write slot suffices.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        src_l_d    = src_l_q;
        if (l_acc && (l_addr != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = l_addr;
            rf_wdata_d = l_data;
            src_l_d    = 1'b1;
        end else if (p_acc && p_nonnull) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = p_addr;
            rf_wdata_d = p_data;
            src_l_d    = 1'b0;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (l_acc) begin
            starve_cnt_d = '0;
        end else if (l_valid && !l_ready && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        starve_d = l_acc ? 1'b0 : (starve_q || (starve_cnt_d == SW'(STARVE_LIMIT)));
    end

    always_comb begin
        outst_d = outst_q;
        if (iss_acc && !l_acc) begin
            outst_d = outst_q + 1'b1;
        end else if (l_acc && !iss_acc && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end
    end

    // Clear follows the registered write so it lands on the RF commit edge; a same-edge issue re-sets the bit.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q && src_l_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (iss_acc && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            src_l_q      <= 1'b0;
            busy_q       <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
            outst_q      <= '0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            src_l_q      <= src_l_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
            outst_q      <= outst_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (rf_we_q) begin
                $display("wb[%s] x%0d = 0x%08X", src_l_q ? "L" : "P", rf_waddr_q, rf_wdata_q);
            end
            if (starve_d && !starve_q) begin
                $display("wb starve");
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed self-checking bench for rf_wb_sched: write latency, scoreboard, starvation, outstanding limit, null requests, async reset.
module tb_rf_wb_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_valid, l_valid, iss_valid;
    logic [4:0]  p_addr, l_addr, iss_rd, chk_rs1, chk_rs2, chk_rd;
    logic [31:0] p_data, l_data;
    logic        p_ready, l_ready, iss_ready, hazard, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_sched #(.STARVE_LIMIT(4), .OUTST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready),
        .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_ready(l_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        p_valid = 0; p_addr = 0; p_data = 0;
        l_valid = 0; l_addr = 0; l_data = 0;
        iss_valid = 0; iss_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        #12;
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wr: we=%0b addr=%0d data=%08h expected 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if (hazard !== 1'b0 || iss_ready !== 1'b1 || p_ready !== 1'b1 || l_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb: hz=%0b isr=%0b pr=%0b lr=%0b expected 0/1/1/0", hazard, iss_ready, p_ready, l_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_p_write();
        p_valid = 1; p_addr = 5; p_data = 32'h12345678;
        #1;
        n_checks++;
        if (p_ready !== 1'b1) begin n_fail++; $display("FAIL p_ready: got %0b expected 1", p_ready); end
        tick();
        p_valid = 0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL p_write: we=%0b addr=%0d data=%08h expected 1/5/12345678", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL p_write_idle: we=%0b addr=%0d data=%08h expected 0/5/12345678 (held)", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_rd = 7; chk_rs1 = 7;
        tick();
        iss_valid = 0;
        #1;
        chk1("hazard_set", hazard, 1'b1);
        l_valid = 1; l_addr = 7; l_data = 32'hDEAD0001;
        #1;
        chk1("l_ready_free", l_ready, 1'b1);
        tick();
        l_valid = 0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD0001) begin
            n_fail++;
            $display("FAIL l_write: we=%0b addr=%0d data=%08h expected 1/7/dead0001", rf_we, rf_waddr, rf_wdata);
        end
        chk1("hazard_hold_1edge", hazard, 1'b1);
        tick();
        chk1("hazard_clear_2edge", hazard, 1'b0);
        chk_rs1 = 0;
    endtask

    task automatic test_starve();
        iss_valid = 1; iss_rd = 9;
        tick();
        iss_valid = 0;
        p_valid = 1; p_addr = 3; p_data = 32'h33;
        l_valid = 1; l_addr = 9; l_data = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_checks++;
            if (l_ready !== 1'b0 || p_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL starve_wait%0d: lr=%0b pr=%0b expected 0/1", i, l_ready, p_ready);
            end
            tick();
            n_checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
                n_fail++;
                $display("FAIL starve_pwr%0d: we=%0b addr=%0d expected 1/3", i, rf_we, rf_waddr);
            end
        end
        #1;
        n_checks++;
        if (l_ready !== 1'b1 || p_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_win: lr=%0b pr=%0b expected 1/0", l_ready, p_ready);
        end
        tick();
        l_valid = 0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin
            n_fail++;
            $display("FAIL starve_lwr: we=%0b addr=%0d data=%08h expected 1/9/99", rf_we, rf_waddr, rf_wdata);
        end
        #1;
        chk1("starve_p_resume", p_ready, 1'b1);
        tick();
        p_valid = 0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            n_fail++;
            $display("FAIL starve_p_after: we=%0b addr=%0d expected 1/3", rf_we, rf_waddr);
        end
        tick();
    endtask

    task automatic test_null();
        p_valid = 1; p_addr = 0; p_data = 32'hFFFF;
        l_valid = 1; l_addr = 12; l_data = 32'hC0C0;
        #1;
        n_checks++;
        if (p_ready !== 1'b1 || l_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL null_both: pr=%0b lr=%0b expected 1/1", p_ready, l_ready);
        end
        tick();
        p_valid = 0;
        l_addr = 0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0C0) begin
            n_fail++;
            $display("FAIL null_lwr: we=%0b addr=%0d data=%08h expected 1/12/c0c0", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        l_valid = 0;
        p_valid = 1;
        chk1("null_l_nowrite", rf_we, 1'b0);
        tick();
        p_valid = 0;
        chk1("null_p_nowrite", rf_we, 1'b0);
    endtask

    task automatic test_outst();
        for (int i = 1; i <= 4; i++) begin
            iss_valid = 1; iss_rd = 5'(i);
            #1;
            chk1("outst_fill_ready", iss_ready, 1'b1);
            tick();
        end
        iss_rd = 11;
        #1;
        chk1("outst_full", iss_ready, 1'b0);
        tick();
        iss_valid = 0; chk_rs1 = 11;
        #1;
        chk1("outst_blocked_nobusy", hazard, 1'b0);
        chk_rs1 = 0;
        l_valid = 1; l_addr = 1; l_data = 32'h1;
        tick();
        l_valid = 0;
        chk1("outst_after_ret", iss_ready, 1'b1);
        iss_valid = 1; iss_rd = 5; l_valid = 1; l_addr = 2; l_data = 32'h2;
        tick();
        iss_valid = 0; l_valid = 0;
        chk1("outst_both_hold", iss_ready, 1'b1);
        iss_valid = 1; iss_rd = 6;
        tick();
        iss_valid = 0;
        chk1("outst_refull", iss_ready, 1'b0);
        l_valid = 1; l_addr = 4; l_data = 32'h4;
        tick();
        l_valid = 0;
        iss_valid = 1; iss_rd = 4; chk_rs1 = 4;
        tick();
        iss_valid = 0;
        chk1("collide_busy_kept", hazard, 1'b1);
        chk1("collide_full", iss_ready, 1'b0);
    endtask

    task automatic test_async_reset();
        p_valid = 1; p_addr = 8; p_data = 32'h88;
        tick();
        p_valid = 0;
        chk1("pre_rst_we", rf_we, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || hazard !== 1'b0 || iss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst: we=%0b addr=%0d data=%08h hz=%0b isr=%0b expected 0/0/0/0/1",
                     rf_we, rf_waddr, rf_wdata, hazard, iss_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        chk1("post_rst_nowrite", rf_we, 1'b0);
    endtask

    initial begin
        test_reset();
        test_p_write();
        test_scoreboard();
        test_starve();
        test_null();
        test_outst();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
